// File: rtl/image_ram_writer.sv
// Streams pixels into a dual-port RAM two at a time: even pixels on port A, odd pixels on port B.
// Odd-sized frames end with a single port-A write.
module image_ram_writer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned NUM_WORDS = 784,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] address_a,
    output logic [ADDR_W-1:0] address_b,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic              wren_a,
    output logic              wren_b,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {StIdle, StEven, StOdd, StDone} state_e;

    localparam logic [ADDR_W-1:0] BaseA    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BaseB    = ADDR_W'(BASE_ADDR + 1);
    localparam logic [ADDR_W:0]   NumWords = (ADDR_W + 1)'(NUM_WORDS);
    localparam logic [ADDR_W:0]   LastIdx  = (ADDR_W + 1)'(NUM_WORDS - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [ADDR_W-1:0] pair_q, pair_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;
    logic              wren_a_q, wren_a_d;
    logic              wren_b_q, wren_b_d;

    logic              accept;
    logic              last_px;
    logic [ADDR_W-1:0] pair_off;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        pair_d   = pair_q;
        wc_d     = wc_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        wren_a_d = 1'b0;
        wren_b_d = 1'b0;

        accept   = in_valid && ((state_q == StEven) || (state_q == StOdd));
        // True when the pixel being accepted is the final one of the frame.
        last_px  = (wc_q == LastIdx);
        pair_off = {pair_q[ADDR_W-2:0], 1'b0};

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    wc_d    = '0;
                    pair_d  = '0;
                    state_d = StEven;
                end
            end
            StEven: begin
                if (in_valid) begin
                    if (last_px) begin
                        wren_a_d = 1'b1;
                        addr_a_d = BaseA + pair_off;
                        data_a_d = in_data;
                        pair_d   = pair_q + ADDR_W'(1);
                        state_d  = StDone;
                    end else begin
                        hold_d  = in_data;
                        state_d = StOdd;
                    end
                end
            end
            StOdd: begin
                if (in_valid) begin
                    wren_a_d = 1'b1;
                    wren_b_d = 1'b1;
                    addr_a_d = BaseA + pair_off;
                    addr_b_d = BaseB + pair_off;
                    data_a_d = hold_q;
                    data_b_d = in_data;
                    pair_d   = pair_q + ADDR_W'(1);
                    state_d  = last_px ? StDone : StEven;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase

        if (accept && (wc_q != NumWords)) begin
            wc_d = wc_q + (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            hold_q   <= '0;
            pair_q   <= '0;
            wc_q     <= '0;
            addr_a_q <= BaseA;
            addr_b_q <= BaseB;
            data_a_q <= '0;
            data_b_q <= '0;
            wren_a_q <= 1'b0;
            wren_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            pair_q   <= pair_d;
            wc_q     <= wc_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            wren_a_q <= wren_a_d;
            wren_b_q <= wren_b_d;
        end
    end

    assign in_ready   = (state_q == StEven) || (state_q == StOdd);
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign address_a  = addr_a_q;
    assign address_b  = addr_b_q;
    assign data_a     = data_a_q;
    assign data_b     = data_b_q;
    assign wren_a     = wren_a_q;
    assign wren_b     = wren_b_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_image_ram_writer.sv
// Scoreboard bench for image_ram_writer: three instances (4, 3 and 784 pixels per frame),
// a frame-level reference model feeding expected writes and status into queues.
module tb_image_ram_writer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [2:0]       start_r    = '0;
    logic [2:0]       in_valid_r = '0;
    logic [2:0][7:0]  in_data_r  = '0;
    logic [2:0]       in_ready_w, wren_a_w, wren_b_w, busy_w, done_w;
    logic [2:0][15:0] addr_a_w, addr_b_w;
    logic [2:0][7:0]  data_a_w, data_b_w;
    logic [2:0][16:0] wc_w;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        image_ram_writer #(
            .DATA_W    (8),
            .ADDR_W    (16),
            .NUM_WORDS ((g == 0) ? 4 : ((g == 1) ? 3 : 784)),
            .BASE_ADDR ((g == 2) ? 'h100 : 0)
        ) u_dut (
            .clock      (clock),
            .reset      (reset),
            .start      (start_r[g]),
            .in_valid   (in_valid_r[g]),
            .in_data    (in_data_r[g]),
            .in_ready   (in_ready_w[g]),
            .address_a  (addr_a_w[g]),
            .address_b  (addr_b_w[g]),
            .data_a     (data_a_w[g]),
            .data_b     (data_b_w[g]),
            .wren_a     (wren_a_w[g]),
            .wren_b     (wren_b_w[g]),
            .busy       (busy_w[g]),
            .done       (done_w[g]),
            .word_count (wc_w[g])
        );
    end

    function automatic int nw(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 3 : 784);
    endfunction

    function automatic int base(input int i);
        return (i == 2) ? 'h100 : 0;
    endfunction

    typedef struct {
        int         inst;
        int         cyc;
        logic [15:0] aa;
        logic [15:0] ab;
        logic [7:0] da;
        logic [7:0] db;
        logic       wb;
        logic       dn;
    } wr_t;

    typedef struct {
        int   inst;
        int   cyc;
        bit   m_rst;
        bit   m_lvl;
        bit   m_end;
        logic rdy;
        logic bsy;
        int   wc;
        int   dcnt;
    } st_t;

    wr_t wr_q[$];
    st_t st_q[$];
    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    int  done_cnt [3] = '{0, 0, 0};

    task automatic chk(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d cyc%0d: got 0x%0h, want 0x%0h", nm, i, cyc, act, exp);
        end
    endtask

    // Monitor: samples just after each rising edge and is the only process that counts.
    always begin
        @(posedge clock);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (wren_a_w[i] || wren_b_w[i]) begin
                if (wr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write inst%0d cyc%0d: got wren %b%b, want none",
                             i, cyc, wren_a_w[i], wren_b_w[i]);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("wr_inst", i, i, e.inst);
                    chk("wr_cycle", i, cyc, e.cyc);
                    chk("wren_a", i, {31'd0, wren_a_w[i]}, 32'd1);
                    chk("wren_b", i, {31'd0, wren_b_w[i]}, {31'd0, e.wb});
                    chk("address_a", i, {16'd0, addr_a_w[i]}, {16'd0, e.aa});
                    chk("data_a", i, {24'd0, data_a_w[i]}, {24'd0, e.da});
                    if (e.wb) begin
                        chk("address_b", i, {16'd0, addr_b_w[i]}, {16'd0, e.ab});
                        chk("data_b", i, {24'd0, data_b_w[i]}, {24'd0, e.db});
                    end
                    chk("done_with_write", i, {31'd0, done_w[i]}, {31'd0, e.dn});
                end
            end else if (done_w[i]) begin
                tests++;
                fails++;
                $display("FAIL done_without_write inst%0d cyc%0d: got done=1, want 0", i, cyc);
            end
            if (done_w[i]) done_cnt[i]++;
        end
        while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
            st_t s;
            int  i;
            s = st_q.pop_front();
            i = s.inst;
            if (s.m_rst) begin
                chk("rst_address_a", i, {16'd0, addr_a_w[i]}, base(i));
                chk("rst_address_b", i, {16'd0, addr_b_w[i]}, base(i) + 1);
                chk("rst_data_a", i, {24'd0, data_a_w[i]}, 0);
                chk("rst_data_b", i, {24'd0, data_b_w[i]}, 0);
                chk("rst_wren", i, {30'd0, wren_a_w[i], wren_b_w[i]}, 0);
                chk("rst_done", i, {31'd0, done_w[i]}, 0);
            end
            if (s.m_lvl) begin
                chk("in_ready", i, {31'd0, in_ready_w[i]}, {31'd0, s.rdy});
                chk("busy", i, {31'd0, busy_w[i]}, {31'd0, s.bsy});
                chk("word_count", i, {15'd0, wc_w[i]}, s.wc);
            end
            if (s.m_end) begin
                chk("done_pulses", i, done_cnt[i], s.dcnt);
                chk("pending_writes", i, wr_q.size(), 0);
            end
        end
    end

    // ---------------- stimulus and reference model ----------------
    logic [7:0] fixed_q[$];
    int         frames [3] = '{0, 0, 0};

    task automatic push_lvl(input int i, input bit rst, input logic rdy, input logic bsy,
                            input int wc);
        st_t s;
        s = '{inst: i, cyc: cyc + 1, m_rst: rst, m_lvl: 1'b1, m_end: 1'b0,
              rdy: rdy, bsy: bsy, wc: wc, dcnt: 0};
        st_q.push_back(s);
    endtask

    // Frame model: pixel 2k goes to base+2k on port A, pixel 2k+1 to base+2k+1 on port B,
    // written in the cycle after the completing pixel is accepted.
    task automatic run_frame(input int i, input int mode);
        int         n;
        int         acc;
        int         guard;
        logic       v;
        logic [7:0] d;
        logic [7:0] prev;
        wr_t        w;
        n     = nw(i);
        acc   = 0;
        guard = 0;
        prev  = '0;
        start_r[i] = 1'b1;
        push_lvl(i, 1'b0, 1'b1, 1'b1, 0);
        @(negedge clock);
        start_r[i] = 1'b0;
        while (acc < n) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ((guard % 2) == 0);
                default: v = 1'(($urandom_range(0, 1)));
            endcase
            if (guard > 300) v = 1'b1;
            if (v && fixed_q.size() > 0) d = fixed_q.pop_front();
            else d = 8'($urandom);
            in_valid_r[i] = v;
            in_data_r[i]  = d;
            start_r[i]    = ($urandom_range(0, 5) == 0);
            if (v) begin
                acc++;
                if ((acc % 2) == 0) begin
                    w = '{inst: i, cyc: cyc + 1, aa: 16'(base(i) + acc - 2),
                          ab: 16'(base(i) + acc - 1), da: prev, db: d, wb: 1'b1, dn: (acc == n)};
                    wr_q.push_back(w);
                end else if (acc == n) begin
                    w = '{inst: i, cyc: cyc + 1, aa: 16'(base(i) + acc - 1), ab: 16'd0,
                          da: d, db: 8'd0, wb: 1'b0, dn: 1'b1};
                    wr_q.push_back(w);
                end
                prev = d;
            end
            push_lvl(i, 1'b0, (acc < n), 1'b1, acc);
            @(negedge clock);
            guard++;
        end
        frames[i]++;
        // DONE cycle: start must be ignored.
        in_valid_r[i] = 1'b0;
        start_r[i]    = 1'b1;
        push_lvl(i, 1'b0, 1'b0, 1'b0, n);
        @(negedge clock);
        // IDLE: pixels must not be accepted.
        start_r[i]    = 1'b0;
        in_valid_r[i] = 1'b1;
        in_data_r[i]  = 8'($urandom);
        push_lvl(i, 1'b0, 1'b0, 1'b0, n);
        @(negedge clock);
        in_valid_r[i] = 1'b0;
    endtask

    initial begin
        st_t s;
        @(negedge clock);
        for (int i = 0; i < 3; i++) push_lvl(i, 1'b1, 1'b0, 1'b0, 0);
        @(negedge clock);
        reset = 1'b0;

        fixed_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(0, 0);
        fixed_q = '{8'hA0, 8'hA1, 8'hA2};
        run_frame(1, 0);
        run_frame(0, 1);

        // Idle with in_valid held: no acceptance, no writes.
        in_valid_r[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data_r[0] = 8'($urandom);
            push_lvl(0, 1'b0, 1'b0, 1'b0, 4);
            @(negedge clock);
        end
        in_valid_r[0] = 1'b0;

        // Reset while holding 0x55 in ODD, with a pixel, start and reset all asserted.
        start_r[0] = 1'b1;
        push_lvl(0, 1'b0, 1'b1, 1'b1, 0);
        @(negedge clock);
        start_r[0]    = 1'b0;
        in_valid_r[0] = 1'b1;
        in_data_r[0]  = 8'h55;
        push_lvl(0, 1'b0, 1'b1, 1'b1, 1);
        @(negedge clock);
        reset        = 1'b1;
        in_data_r[0] = 8'h66;
        start_r[0]   = 1'b1;
        push_lvl(0, 1'b1, 1'b0, 1'b0, 0);
        @(negedge clock);
        reset         = 1'b0;
        start_r[0]    = 1'b0;
        in_valid_r[0] = 1'b0;
        run_frame(0, 0);

        for (int k = 0; k < 3; k++) begin
            run_frame(0, 2);
            run_frame(1, 2);
        end
        run_frame(2, 0);
        run_frame(2, 2);

        for (int i = 0; i < 3; i++) begin
            s = '{inst: i, cyc: cyc + 1, m_rst: 1'b0, m_lvl: 1'b0, m_end: 1'b1,
                  rdy: 1'b0, bsy: 1'b0, wc: 0, dcnt: frames[i]};
            st_q.push_back(s);
        end
        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/image_ram_writer.md
IMAGE_RAM_WRITER -- requirements
Module: image_ram_writer

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits.
REQ-002 Parameter ADDR_W, default 16, RAM address width.
REQ-003 Parameter NUM_WORDS, default 784, pixels per frame; legal range 1..2^ADDR_W-BASE_ADDR.
REQ-004 Parameter BASE_ADDR, default 0, first RAM address of the frame; SHALL be even.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 start  input  1  one-cycle request to begin loading a frame.
REQ-008 in_valid  input  1  in_data holds a pixel.
REQ-009 in_data  input  DATA_W  pixel value.
REQ-010 in_ready  output  1  block accepts a pixel this cycle.
REQ-011 address_a / address_b  output  ADDR_W each  port A (even) and port B (odd) write addresses.
REQ-012 data_a / data_b  output  DATA_W each  port A / port B write data.
REQ-013 wren_a / wren_b  output  1 each  port write strobes.
REQ-014 busy  output  1  frame load in progress.
REQ-015 done  output  1  one-cycle frame-complete pulse.
REQ-016 word_count  output  ADDR_W+1  pixels accepted in the current or last frame.

Function
REQ-017 A pixel SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-018 The FSM SHALL have exactly the states IDLE, EVEN, ODD and DONE.
REQ-019 IDLE: in_ready=0 and busy=0; start=1 SHALL clear word_count and the pair index and move to EVEN.
REQ-020 EVEN: in_ready=1 and busy=1; an accepted pixel SHALL be stored in a hold register, and the FSM SHALL move to ODD.
REQ-021 EVEN, when the accepted pixel is the last of an odd-sized frame: the FSM SHALL instead issue a port-A-only write (wren_a=1, wren_b=0) and move to DONE.
REQ-022 ODD: in_ready=1 and busy=1; an accepted pixel SHALL cause a paired write one cycle later: wren_a=wren_b=1, data_a=held pixel, data_b=new pixel, address_a=BASE_ADDR+2k, address_b=BASE_ADDR+2k+1 (k=pair index).
REQ-023 After a paired write, the FSM SHALL move to DONE if word_count reaches NUM_WORDS, else to EVEN.
REQ-024 Write strobes SHALL be registered, SHALL appear in the cycle after the accepting cycle, and SHALL last exactly one cycle; sustained in_valid=1 SHALL give 1 pixel/cycle throughput with no bubbles.
REQ-025 The pair index SHALL increment by 1 per write; address_a/address_b SHALL hold their last values while the strobes are 0, and so SHALL data_a/data_b.
REQ-026 word_count SHALL increment by 1 per accepted pixel and saturate at NUM_WORDS.
REQ-027 DONE: in_ready=0, busy=1, done=1 for exactly one cycle, which is the cycle of the final write strobe; the FSM SHALL then return to IDLE.
REQ-028 start SHALL be ignored in every state except IDLE.
REQ-029 in_data SHALL be ignored while in_ready=0.
REQ-030 Addresses SHALL never exceed BASE_ADDR+NUM_WORDS-1, and no write SHALL occur outside a frame.

Reset
REQ-031 When reset=1, the block SHALL enter IDLE and drive these outputs on the next edge: address_a=BASE_ADDR, address_b=BASE_ADDR+1, data_a=data_b=0, wren_a=wren_b=0, in_ready=0, busy=0, done=0, word_count=0.
REQ-032 Reset SHALL take priority over start and in_valid, and a reset mid-frame SHALL suppress any pending write strobe.
REQ-033 There SHALL be no initial-value dependence; behaviour before the first reset is undefined.

Verification
REQ-034 NUM_WORDS=4, start, then pixels 0x11,0x22,0x33,0x44 on consecutive cycles. Required: writes (0,1,0x11,0x22) and (2,3,0x33,0x44) on consecutive cycles; done in the second write cycle; word_count=4.
REQ-035 NUM_WORDS=3, pixels 0xA0,0xA1,0xA2. Required: paired write (0,1), then a port-A-only write at address 2 with data 0xA2 and wren_b=0; done pulses with it.
REQ-036 in_valid toggled 1,0,1,0 with NUM_WORDS=2. Required: no strobe until the second pixel is accepted; exactly one paired write; in_ready stays 1 during the gaps.
REQ-037 Reset asserted while in ODD holding 0x55. Required: next cycle wren_a=wren_b=0, busy=0, address_a=0, address_b=1, word_count=0; a new frame restarts at address 0.
REQ-038 start pulsed while busy, and in_valid=1 while in IDLE. Required: no restart, no acceptance, no writes, and word_count unchanged.
REQ-039 NUM_WORDS=784 with BASE_ADDR=0x100. Required: 392 paired writes, last addresses 0x40E/0x40F, done exactly once.
